// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Purpose:
//   Bounds how long the core may run freely. Counts rising edges of core_clock
//   (sampled as data in the clock_100mhz domain) against a programmable target
//   and raises countdown_timed_up once the target is exhausted. Clock control
//   holds the timer idle through countdown_reset while in manual mode.
//
// Parameters:
//   WIDTH          width of the target register and remaining counter
//   DEFAULT_COUNT  target value after reset; 0 disables the timer
//
// Ports:
//   clock_100mhz        in   system clock, all state on its rising edge
//   reset_n             in   asynchronous active-low reset
//   countdown_reset     in   level; high holds the timer idle, clears expiry
//   core_clock          in   core clock sampled as data; rising edges counted
//   load_strobe         in   one-cycle write strobe for the target register
//   load_value          in   new target, captured when load_strobe is high
//   countdown_timed_up  out  registered; high while EXPIRED
//   cycles_remaining    out  registered remaining count
//   timer_armed         out  registered; high while ARMED
//
// Build option:
//   COUNTDOWN_EDGE_SYNC_EN  when defined, core_clock passes through a 2-flop
//                           synchronizer ahead of the edge detector (adds two
//                           cycles of decrement latency). Leave undefined when
//                           core_clock comes from a clock_100mhz register.
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int               WIDTH         = 32,
    parameter logic [WIDTH-1:0] DEFAULT_COUNT = '0
) (
    input  logic             clock_100mhz,
    input  logic             reset_n,
    input  logic             countdown_reset,
    input  logic             core_clock,
    input  logic             load_strobe,
    input  logic [WIDTH-1:0] load_value,
    output logic             countdown_timed_up,
    output logic [WIDTH-1:0] cycles_remaining,
    output logic             timer_armed
);

    // One-hot so each status output is a single flop bit (glitch-free).
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_ARMED   = 3'b010,
        ST_EXPIRED = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             core_prev_q, core_prev_d;
    logic             core_sample;
    logic             core_edge;
    logic             last_step;

    // ------------------------------------------------------------------
    // core_clock sampling and edge detection
    // ------------------------------------------------------------------
`ifdef COUNTDOWN_EDGE_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], core_clock};
    end

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign core_sample = sync_q[1];
`else
    // core_clock already lives in this domain; only the history flop is needed.
    assign core_sample = core_clock;
`endif

    always_comb begin
        core_prev_d = core_sample;
    end

    // A constant-high core_clock never produces an edge.
    assign core_edge = core_sample & ~core_prev_q;

    // The decrement that reaches zero is the expiring one.
    assign last_step = (cnt_q == WIDTH'(1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. countdown_reset outranks edges and expiry.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!countdown_reset && (target_q != '0)) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (countdown_reset) begin
                    state_d = ST_IDLE;
                end else if (core_edge && last_step) begin
                    state_d = ST_EXPIRED;
                end
            end
            ST_EXPIRED: begin
                if (countdown_reset) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded straight from the one-hot state flops
    // ------------------------------------------------------------------
    always_comb begin
        countdown_timed_up = state_q[2];
        timer_armed        = state_q[1];
    end

    // ------------------------------------------------------------------
    // Datapath: target register and remaining counter
    // ------------------------------------------------------------------
    always_comb begin
        // A write never disturbs a run in progress; IDLE reloads from the
        // current (pre-write) target, so the new value shows up next cycle.
        target_d = load_strobe ? load_value : target_q;

        cnt_d = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = target_q;
            end
            ST_ARMED: begin
                if (!countdown_reset && core_edge) begin
                    cnt_d = last_step ? '0 : (cnt_q - WIDTH'(1));
                end
            end
            ST_EXPIRED: begin
                cnt_d = cnt_q;
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            target_q    <= DEFAULT_COUNT;
            cnt_q       <= '0;
            core_prev_q <= 1'b0;
        end else begin
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            core_prev_q <= core_prev_d;
        end
    end

    assign cycles_remaining = cnt_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int WIDTH = 32;
`ifdef COUNTDOWN_EDGE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             countdown_reset = 1'b1;
    logic             core_clock = 1'b0;
    logic             load_strobe = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             countdown_timed_up;
    logic [WIDTH-1:0] cycles_remaining;
    logic             timer_armed;

    int errors = 0;
    int checks = 0;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clock_100mhz      (clk),
        .reset_n           (reset_n),
        .countdown_reset   (countdown_reset),
        .core_clock        (core_clock),
        .load_strobe       (load_strobe),
        .load_value        (load_value),
        .countdown_timed_up(countdown_timed_up),
        .cycles_remaining  (cycles_remaining),
        .timer_armed       (timer_armed)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // The timer is described as "is it running", "has it run out" and
    // "how many counted edges are left"; core edges come from a history
    // of raw samples, delayed by the synchronizer depth.
    int unsigned m_target = 0;
    int unsigned m_left   = 0;
    bit          m_running = 0;
    bit          m_done    = 0;
    bit          hist[$];

    task automatic model_reset();
        m_target  = 0;   // DEFAULT_COUNT
        m_left    = 0;
        m_running = 0;
        m_done    = 0;
        hist.delete();
        for (int i = 0; i < LAT + 2; i++) hist.push_back(1'b0);
    endtask

    task automatic model_step();
        bit          edge_seen;
        int unsigned old_target;
        if (!reset_n) begin
            model_reset();
            return;
        end
        hist.push_front(core_clock);
        edge_seen = hist[LAT] && !hist[LAT+1];
        void'(hist.pop_back());
        old_target = m_target;
        if (load_strobe) m_target = load_value;
        if (!m_running && !m_done) begin
            m_left = old_target;
            if (!countdown_reset && old_target != 0) m_running = 1;
        end else if (m_running) begin
            if (countdown_reset) begin
                m_running = 0;
            end else if (edge_seen) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_running = 0;
                    m_done    = 1;
                end
            end
        end else begin
            if (countdown_reset) m_done = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".remaining"}, cycles_remaining, m_left);
        chk({tag, ".timed_up"}, {31'd0, countdown_timed_up}, {31'd0, m_done});
        chk({tag, ".armed"}, {31'd0, timer_armed}, {31'd0, m_running});
        $display("step %s: rem=%0d up=%0b armed=%0b", tag, cycles_remaining,
                 countdown_timed_up, timer_armed);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk_all(tag);
    endtask

    // One core_clock rising edge: high for 3 cycles, low for 3 cycles.
    task automatic core_pulse(input string tag);
        core_clock = 1'b1;
        repeat (3) tick(tag);
        core_clock = 1'b0;
        repeat (3) tick(tag);
    endtask

    initial begin
        model_reset();

        // Reset state
        #2;
        chk("reset.remaining", cycles_remaining, 0);
        chk("reset.timed_up", {31'd0, countdown_timed_up}, 0);
        chk("reset.armed", {31'd0, timer_armed}, 0);
        tick("reset_hold");
        @(negedge clk);
        reset_n = 1'b1;

        // Disabled timer: target 0, toggling core_clock, never arms
        countdown_reset = 1'b0;
        for (int i = 0; i < 6; i++) core_pulse("disabled");
        chk("disabled.remaining", cycles_remaining, 0);
        chk("disabled.timed_up", {31'd0, countdown_timed_up}, 0);

        // Load 5, reset pulse, arm
        load_strobe = 1'b1; load_value = 5;
        tick("load5");
        load_strobe = 1'b0;
        countdown_reset = 1'b1; tick("cr_hi");
        countdown_reset = 1'b0; tick("arm");
        chk("arm5.armed", {31'd0, timer_armed}, 1);
        chk("arm5.remaining", cycles_remaining, 5);
        for (int i = 1; i <= 5; i++) begin
            core_pulse("count5");
            chk("count5.step", cycles_remaining, 32'(5 - i));
        end
        chk("expire5.timed_up", {31'd0, countdown_timed_up}, 1);
        core_pulse("edge6");
        chk("edge6.remaining", cycles_remaining, 0);
        chk("edge6.timed_up", {31'd0, countdown_timed_up}, 1);

        // Clear from EXPIRED, reload, rearm
        countdown_reset = 1'b1; tick("clear");
        chk("clear.timed_up", {31'd0, countdown_timed_up}, 0);
        tick("reload");
        chk("reload.remaining", cycles_remaining, 5);
        countdown_reset = 1'b0; tick("rearm");
        chk("rearm.armed", {31'd0, timer_armed}, 1);

        // Load 10 mid-run at 3: current run unaffected
        core_pulse("mid"); core_pulse("mid");
        chk("mid.remaining", cycles_remaining, 3);
        load_strobe = 1'b1; load_value = 10;
        tick("load10");
        load_strobe = 1'b0;
        for (int i = 0; i < 3; i++) core_pulse("finish3");
        chk("finish3.timed_up", {31'd0, countdown_timed_up}, 1);
        countdown_reset = 1'b1; tick("clr10"); tick("clr10");
        countdown_reset = 1'b0; tick("arm10");
        chk("arm10.remaining", cycles_remaining, 10);

        // countdown_reset coincides with the final edge: no expiry
        for (int i = 0; i < 9; i++) core_pulse("to1");
        chk("to1.remaining", cycles_remaining, 1);
        core_clock = 1'b1;
        repeat (LAT) tick("sync_wait");
        countdown_reset = 1'b1;
        tick("race");
        chk("race.timed_up", {31'd0, countdown_timed_up}, 0);
        chk("race.armed", {31'd0, timer_armed}, 0);
        tick("race2");
        core_clock = 1'b0;
        repeat (3) tick("race3");
        countdown_reset = 1'b0;

        // Asynchronous reset while ARMED at 7
        tick("arm_again");
        for (int i = 0; i < 3; i++) core_pulse("to7");
        chk("to7.remaining", cycles_remaining, 7);
        reset_n = 1'b0;
        #1;
        chk("async.remaining", cycles_remaining, 0);
        chk("async.armed", {31'd0, timer_armed}, 0);
        chk("async.timed_up", {31'd0, countdown_timed_up}, 0);
        model_reset();
        tick("rst_low");
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) core_pulse("post_rst");
        chk("post_rst.armed", {31'd0, timer_armed}, 0);

        // Randomized phase
        for (int i = 0; i < 500; i++) begin
            core_clock = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) countdown_reset = ~countdown_reset;
            load_strobe = ($urandom_range(0, 15) == 0);
            load_value  = 32'($urandom_range(0, 6));
            tick("rand");
        end
        load_strobe = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
